// File: rtl/opn_bus_pkg.sv
// ============================================================================
// Module : opn_bus_pkg
// Brief  : Shared types and constants for the OPN host bus responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package opn_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int STAT_BUSY   = 7;
    localparam int STAT_OVF    = 6;
    localparam int STAT_FLAG_B = 1;
    localparam int STAT_FLAG_A = 0;

    localparam logic [7:0] REG_KON     = 8'h28;
    localparam logic [7:0] REG_FBCN    = 8'hB0;
    localparam logic [7:0] REG_FNUM_LO = 8'hA0;
    localparam logic [7:0] REG_FNUM_HI = 8'hA4;
    localparam logic [7:0] REG_DTMUL   = 8'h30;

    function automatic logic [7:0] status_byte(input logic busy, input logic ovf,
                                               input logic flag_b, input logic flag_a);
        logic [7:0] s;
        s              = 8'h00;
        s[STAT_BUSY]   = busy;
        s[STAT_OVF]    = ovf;
        s[STAT_FLAG_B] = flag_b;
        s[STAT_FLAG_A] = flag_a;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/opn_wr_fifo.sv
// ============================================================================
// Module : opn_wr_fifo
// Brief  : Synchronous FIFO for queued {addr,data} writes; pop before push.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opn_wr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/opn_cpu_if.sv
// ============================================================================
// Module : opn_cpu_if
// Brief  : OPN host bus responder: A0-phased writes -> paced MMR strobes, status.
//          OPN_CPU_IF_WRITE_FIFO_EN selects a FIFO_DEPTH queue over a single slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opn_cpu_if
    import opn_bus_pkg::*;
#(
    parameter int BUSY_CYCLES = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cen,
    input  logic [7:0] i_din,
    input  logic       i_addr,
    input  logic       i_cs_n,
    input  logic       i_wr_n,
    input  logic       i_rd_n,
    input  logic       i_flag_a,
    input  logic       i_flag_b,
    output logic [7:0] o_dout,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_data,
    output logic       o_reg_we,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam logic [7:0] c_HOLD_LOAD = 8'(BUSY_CYCLES);

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_wr_n_d;
    logic        r_rd_act;
    logic [7:0]  r_alat;
    logic        r_alat_v;
    logic        r_ovf;
    logic [7:0]  r_dout;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_reg_data;
    logic [7:0]  r_hold;
    logic        w_wr_edge;
    logic        w_data_wr;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_load;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_head;
    logic        w_rd_active;

    assign w_wr_edge   = ~i_cs_n & ~i_wr_n & r_wr_n_d;
    assign w_data_wr   = w_wr_edge & i_addr & r_alat_v;
    assign w_rd_active = ~i_cs_n & ~i_rd_n;

`ifdef OPN_CPU_IF_WRITE_FIFO_EN
    // A full queue still accepts when the drain pops the head this cycle.
    assign w_push = w_data_wr & (~w_full | w_pop);
    assign w_drop = w_data_wr & ~w_push;

    opn_wr_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_alat, i_din}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    logic        r_hv;
    logic [15:0] r_hdata;
    logic        w_busy_core;

    assign w_full      = r_hv & (FIFO_DEPTH > 0);
    assign w_empty     = ~r_hv;
    assign w_head      = r_hdata;
    assign w_busy_core = w_full | (r_state == ST_ISSUE) | (r_hold != 8'd0);
    assign w_push      = w_data_wr & ~w_busy_core;
    assign w_drop      = w_data_wr & w_busy_core;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hv    <= 1'b0;
            r_hdata <= 16'h0000;
        end else if (w_push) begin
            r_hv    <= 1'b1;
            r_hdata <= {r_alat, i_din};
        end else if (w_pop) begin
            r_hv    <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cen && !w_empty) begin
                    w_pop      = 1'b1;
                    w_load     = 1'b1;
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_cen) w_state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_cen && r_hold == 8'd0) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_load     = 1'b1;
                        w_state_nx = ST_ISSUE;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_n_d   <= 1'b1;
            r_rd_act   <= 1'b0;
            r_alat     <= 8'h00;
            r_alat_v   <= 1'b0;
            r_ovf      <= 1'b0;
            r_dout     <= 8'h00;
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
            r_hold     <= 8'h00;
        end else begin
            r_state  <= w_state_nx;
            r_wr_n_d <= i_wr_n;
            r_rd_act <= w_rd_active;
            if (w_wr_edge && !i_addr) begin
                r_alat   <= i_din;
                r_alat_v <= 1'b1;
            end
            if (w_drop)                        r_ovf <= 1'b1;
            else if (r_rd_act && !w_rd_active) r_ovf <= 1'b0;
            r_dout <= w_rd_active ? status_byte(o_busy, r_ovf, i_flag_b, i_flag_a) : 8'h00;
            // Hold is armed as the issue slot begins so busy spans exactly BUSY_CYCLES+1 cen.
            if (w_load) begin
                r_reg_addr <= w_head[15:8];
                r_reg_data <= w_head[7:0];
                r_hold     <= c_HOLD_LOAD;
            end else if (i_cen && r_hold != 8'd0) begin
                r_hold     <= r_hold - 8'd1;
            end
        end
    end

    assign o_reg_we   = (r_state == ST_ISSUE) & i_cen;
    assign o_busy     = w_push | ~w_empty | (r_state == ST_ISSUE) | (r_hold != 8'd0);
    assign o_ovf      = r_ovf;
    assign o_dout     = r_dout;
    assign o_reg_addr = r_reg_addr;
    assign o_reg_data = r_reg_data;

endmodule

`default_nettype wire

// File: tb/tb_opn_cpu_if.sv
// ============================================================================
// Module : tb_opn_cpu_if
// Brief  : Directed self-checking bench for opn_cpu_if (either queue build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_opn_cpu_if;

`ifdef OPN_CPU_IF_WRITE_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       cen    = 1'b1;
    logic [7:0] din    = 8'h00;
    logic       addr   = 1'b0;
    logic       cs_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic       rd_n   = 1'b1;
    logic       flag_a = 1'b0;
    logic       flag_b = 1'b0;
    logic [7:0] dout;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we;
    logic       busy;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int we_pulses, we_clks, we_bad;
    logic we_prev = 1'b0;
    logic [7:0] last_a, last_d;
    int   rise_cyc[$];
    logic [7:0] rise_dat[$];
    bit   cen_div = 1'b0;
    int   cen_ph  = 0;

    opn_cpu_if #(.BUSY_CYCLES(32), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cen      (cen),
        .i_din      (din),
        .i_addr     (addr),
        .i_cs_n     (cs_n),
        .i_wr_n     (wr_n),
        .i_rd_n     (rd_n),
        .i_flag_a   (flag_a),
        .i_flag_b   (flag_b),
        .o_dout     (dout),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_reg_we   (reg_we),
        .o_busy     (busy),
        .o_ovf      (ovf)
    );

    always #5 clk = ~clk;

    // cen either stays high or pulses once every six clocks
    always @(posedge clk) begin
        #1;
        if (cen_div) begin
            cen    = (cen_ph == 5);
            cen_ph = (cen_ph == 5) ? 0 : cen_ph + 1;
        end else begin
            cen = 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (reg_we) begin
            we_clks++;
            if (!cen) we_bad++;
            if (!we_prev) begin
                we_pulses++;
                rise_cyc.push_back(cyc);
                rise_dat.push_back(reg_data);
                last_a = reg_addr;
                last_d = reg_data;
            end
        end
        we_prev = reg_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        we_pulses = 0; we_clks = 0; we_bad = 0;
        last_a = 8'h00; last_d = 8'h00;
        rise_cyc.delete(); rise_dat.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr = 1'b0; din = 8'h00; cen_div = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        @(posedge clk); #1;
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(posedge clk); #1;
        wr_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic bus_rd(output logic [7:0] v);
        @(posedge clk); #1;
        cs_n = 1'b0; rd_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v = dout;
        @(posedge clk); #1;
        rd_n = 1'b1; cs_n = 1'b1;
    endtask

    // counts cen cycles with busy high, starting the clock after the push
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (cen) n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({dout, reg_addr, reg_data, reg_we, busy, ovf} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {dout, reg_addr, reg_data, reg_we, busy, ovf});
        end
    endtask

    task automatic test_single_write();
        int n, c0;
        do_reset(); clr_mon();
        bus_wr(1'b0, opn_bus_pkg::REG_KON);
        bus_wr(1'b1, 8'h10);
        c0 = cyc;
        count_busy(n);
        idle(3);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL single_busy_len: got %0d required 33", n); end
        checks++;
        if (we_pulses !== 1 || we_clks !== 1) begin
            errors++; $display("FAIL single_we_count: got %0d pulses %0d clks required 1 1", we_pulses, we_clks);
        end
        checks++;
        if (last_a !== 8'h28 || last_d !== 8'h10) begin
            errors++; $display("FAIL single_we_payload: got %h/%h required 28/10", last_a, last_d);
        end
        checks++;
        if (rise_cyc.size() < 1 || rise_cyc[0] - c0 < 1 || rise_cyc[0] - c0 > 2) begin
            errors++; $display("FAIL single_latency: got %0d pulses, first at offset %0d required 1..2",
                               rise_cyc.size(), (rise_cyc.size() > 0) ? rise_cyc[0] - c0 : -1);
        end
        checks++;
        if (reg_addr !== 8'h28 || reg_data !== 8'h10) begin
            errors++; $display("FAIL single_stable: got %h/%h required 28/10", reg_addr, reg_data);
        end
    endtask

    task automatic test_back_to_back();
        int sp, exp_sp, exp_n;
        do_reset(); clr_mon();
        bus_wr(1'b0, opn_bus_pkg::REG_FBCN);
        bus_wr(1'b1, 8'h07);
        bus_wr(1'b1, 8'h05);
        idle(80);
        exp_n  = FIFO_EN ? 2 : 1;
        exp_sp = FIFO_EN ? 33 : 0;
        sp     = (rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : 0;
        checks++;
        if (we_pulses !== exp_n) begin errors++; $display("FAIL b2b_count: got %0d required %0d", we_pulses, exp_n); end
        checks++;
        if (rise_dat.size() < 1 || rise_dat[0] !== 8'h07 || last_a !== 8'hB0) begin
            errors++; $display("FAIL b2b_first: got %0d entries addr %h required data 07 addr B0", rise_dat.size(), last_a);
        end
        checks++;
        if (last_d !== (FIFO_EN ? 8'h05 : 8'h07)) begin
            errors++; $display("FAIL b2b_last: got %h required %h", last_d, FIFO_EN ? 8'h05 : 8'h07);
        end
        checks++;
        if (sp !== exp_sp) begin errors++; $display("FAIL b2b_spacing: got %0d required %0d", sp, exp_sp); end
        checks++;
        if (ovf !== !FIFO_EN) begin errors++; $display("FAIL b2b_ovf: got %b required %b", ovf, !FIFO_EN); end
    endtask

    task automatic test_no_addr();
        do_reset(); clr_mon();
        bus_wr(1'b1, 8'h55);
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL noaddr_flags: got busy %b ovf %b required 0 0", busy, ovf);
        end
        idle(10);
        checks++;
        if (we_pulses !== 0) begin errors++; $display("FAIL noaddr_we: got %0d required 0", we_pulses); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        do_reset(); clr_mon();
        flag_a = 1'b1; flag_b = 1'b0;
        bus_wr(1'b0, opn_bus_pkg::REG_FNUM_HI);
        for (int i = 1; i <= 6; i++) bus_wr(1'b1, 8'h10 + 8'(i));
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf); end
        bus_rd(v);
        checks++;
        if (v !== 8'hC1) begin errors++; $display("FAIL ovf_status: got %h required c1", v); end
        idle(2);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ovf); end
        flag_b = 1'b1;
        bus_rd(v);
        checks++;
        if (v !== 8'h83) begin errors++; $display("FAIL ovf_status2: got %h required 83", v); end
        flag_a = 1'b0; flag_b = 1'b0;
        idle(250);
        checks++;
        if (we_pulses !== (FIFO_EN ? 5 : 1)) begin
            errors++; $display("FAIL ovf_we_count: got %0d required %0d", we_pulses, FIFO_EN ? 5 : 1);
        end
        checks++;
        if (last_a !== 8'hA4 || last_d !== (FIFO_EN ? 8'h15 : 8'h11)) begin
            errors++; $display("FAIL ovf_last: got %h/%h required a4/%h", last_a, last_d, FIFO_EN ? 8'h15 : 8'h11);
        end
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_idle: got dout %h busy %b required 00 0", dout, busy);
        end
    endtask

    task automatic test_held_wr_slow_cen();
        int n;
        do_reset(); clr_mon();
        bus_wr(1'b0, opn_bus_pkg::REG_DTMUL);
        cen_div = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h3C;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin wr_n = 1'b1; cs_n = 1'b1; end
            @(negedge clk);
            if (!busy) break;
            if (cen) n++;
        end
        idle(12);
        cen_div = 1'b0;
        checks++;
        if (n !== 33) begin errors++; $display("FAIL slow_busy_len: got %0d required 33", n); end
        checks++;
        if (we_pulses !== 1 || we_clks !== 1) begin
            errors++; $display("FAIL slow_we_count: got %0d pulses %0d clks required 1 1", we_pulses, we_clks);
        end
        checks++;
        if (we_bad !== 0) begin errors++; $display("FAIL slow_we_no_cen: got %0d required 0", we_bad); end
        checks++;
        if (last_a !== 8'h30 || last_d !== 8'h3C) begin
            errors++; $display("FAIL slow_payload: got %h/%h required 30/3c", last_a, last_d);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset(); clr_mon();
        bus_wr(1'b0, opn_bus_pkg::REG_FBCN);
        bus_wr(1'b1, 8'h01);
        bus_wr(1'b1, 8'h02);
        bus_wr(1'b1, 8'h03);
        idle(5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b required 1", busy); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, reg_addr, reg_data, reg_we, busy, ovf} !== 27'd0) begin
            errors++; $display("FAIL midrst_outputs: got %h required 0", {dout, reg_addr, reg_data, reg_we, busy, ovf});
        end
        idle(2);
        rst_n = 1'b1;
        clr_mon();
        idle(100);
        checks++;
        if (we_pulses !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_flushed: got %0d pulses busy %b required 0 0", we_pulses, busy);
        end
        bus_wr(1'b1, 8'h33);
        idle(10);
        checks++;
        if (we_pulses !== 0) begin errors++; $display("FAIL midrst_alat_cleared: got %0d required 0", we_pulses); end
        bus_wr(1'b0, opn_bus_pkg::REG_KON);
        bus_wr(1'b1, 8'h44);
        idle(5);
        checks++;
        if (we_pulses !== 1 || last_a !== 8'h28 || last_d !== 8'h44) begin
            errors++; $display("FAIL midrst_new_pair: got %0d pulses %h/%h required 1 28/44", we_pulses, last_a, last_d);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_no_addr();
        test_overflow();
        test_held_wr_slow_cen();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
